div_iter: RTL and testbench

- Parametrised, sequential successor to the single-cycle 8/5-bit restoring divider.
- Computes unsigned `A_W`-bit dividend / `B_W`-bit divisor as an iterative radix-2 restoring divider, one quotient bit per clock.
- Valid/ready handshake on input and output, plus divide-by-zero detection.
- Sits between operand registers and the result consumer; reports its transistor count on `number`, like every other block in the library.

---
 rtl/div_iter_pkg.sv | 22 ++
 rtl/div_step.sv | 36 +++
 rtl/div_iter.sv | 120 ++++++++++++
 tb/tb_div_iter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative restoring divider: state encodings,
// the width of the transistor-count bus and the per-cell transistor counts.
package div_iter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int NUM_W  = 51;
  localparam int FSP_T  = 28;
  localparam int MUXP_T = 12;
  localparam int INV_T  = 2;
  localparam int REGP_T = 26;
  localparam int CTRL_T = 60;

  function automatic logic [NUM_W-1:0] cells(input int n, input int t);
    return NUM_W'(n) * NUM_W'(t);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: ripple-borrow subtract of the divisor from the
// shifted partial remainder, then select difference or original.
module div_step
  import div_iter_pkg::*;
#(
  parameter int B_W = 5
) (
  input  logic [B_W:0]       i_t,
  input  logic [B_W-1:0]     i_b,
  output logic [B_W-1:0]     o_pr,
  output logic               o_qbit,
  output logic [NUM_W-1:0]   number
);

  logic [B_W+1:0] bor;
  logic [B_W:0]   b_ext;
  logic [B_W-1:0] diff;

  assign b_ext  = {1'b0, i_b};
  assign bor[0] = 1'b0;

  for (genvar i = 0; i <= B_W; i++) begin : g_fsp
    assign bor[i+1] = (~i_t[i] & b_ext[i]) | (~(i_t[i] ^ b_ext[i]) & bor[i]);
    if (i < B_W) begin : g_diff
      assign diff[i] = i_t[i] ^ b_ext[i] ^ bor[i];
    end
  end

  // The kept remainder is always below the divisor, so its top bit is zero
  // and only the low B_W bits are selected.
  assign o_qbit = ~bor[B_W+1];
  assign o_pr   = o_qbit ? diff : i_t[B_W-1:0];

  assign number = cells(B_W + 1, FSP_T) + cells(B_W, MUXP_T) + cells(1, INV_T);

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, one quotient bit per clock, with
// valid/ready handshakes and divide-by-zero reporting.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int A_W   = 8,
  parameter int B_W   = 5,
  parameter int CNT_W = $clog2(A_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [A_W-1:0]     i_a,
  input  logic [B_W-1:0]     i_b,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [A_W-1:0]     o_q,
  output logic [B_W-1:0]     o_r,
  output logic               o_dbz,
  output logic [NUM_W-1:0]   number
);

  state_e             state_q, state_d;
  logic [A_W-1:0]     a_sh_q, a_sh_d;
  logic [B_W-1:0]     pr_q, pr_d;
  logic [B_W-1:0]     b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dbz_q, dbz_d;

  logic [B_W-1:0]     step_pr;
  logic               step_qbit;
  logic [NUM_W-1:0]   step_num;

  div_step #(.B_W(B_W)) u_step (
    .i_t    ({pr_q, a_sh_q[A_W-1]}),
    .i_b    (b_q),
    .o_pr   (step_pr),
    .o_qbit (step_qbit),
    .number (step_num)
  );

  // Next-state and datapath update; a zero divisor spends one BUSY cycle
  // loading the saturated quotient and the raw low dividend bits.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    pr_d    = pr_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (i_in_valid) begin
          a_sh_d  = i_a;
          b_d     = i_b;
          pr_d    = '0;
          cnt_d   = CNT_W'(A_W - 1);
          dbz_d   = (i_b == '0);
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (dbz_q) begin
          a_sh_d  = '1;
          pr_d    = a_sh_q[B_W-1:0];
          state_d = S_DONE;
        end else begin
          a_sh_d = {a_sh_q[A_W-2:0], step_qbit};
          pr_d   = step_pr;
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        if (i_out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      pr_q    <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      pr_q    <= pr_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  assign o_in_ready  = (state_q == S_IDLE);
  assign o_out_valid = (state_q == S_DONE);
  assign o_q         = a_sh_q;
  assign o_r         = pr_q;
  assign o_dbz       = dbz_q;

  assign number = step_num
                + cells(A_W + 2 * B_W + CNT_W + 3, REGP_T)
                + cells(1, CTRL_T);

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: arithmetic scoreboard plus directed
// latency, throughput, hold, divide-by-zero and reset scenarios.
module tb_div_iter;

  localparam int A_W = 8;
  localparam int B_W = 5;
  localparam int NUMBER_EXP = 914;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [A_W-1:0] i_a;
  logic [B_W-1:0] i_b;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [A_W-1:0] o_q;
  logic [B_W-1:0] o_r;
  logic          o_dbz;
  logic [50:0]   number;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc = 0;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    bit dbz;
  } exp_t;
  exp_t expq[$];

  div_iter #(.A_W(A_W), .B_W(B_W)) dut (
    .clk(clk), .rst(rst),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_a(i_a), .i_b(i_b),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_q(o_q), .o_r(o_r), .o_dbz(o_dbz), .number(number)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Scoreboard: record accepted operands with the arithmetic answer, retire on output handshake.
  always @(posedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      expq.delete();
    end else begin
      if (o_out_valid && i_out_ready && expq.size() > 0) void'(expq.pop_front());
      if (i_in_valid && o_in_ready) begin
        e.a = int'(i_a);
        e.b = int'(i_b);
        if (i_b == 0) begin
          e.q = (1 << A_W) - 1;
          e.r = int'(i_a) % (1 << B_W);
          e.dbz = 1'b1;
        end else begin
          e.q = int'(i_a) / int'(i_b);
          e.r = int'(i_a) % int'(i_b);
          e.dbz = 1'b0;
        end
        expq.push_back(e);
      end
    end
  end

  // Compare every cycle the result is presented.
  always @(negedge clk) begin : compare
    exp_t e;
    if (!rst && o_out_valid) begin
      if (expq.size() == 0) begin
        check("spurious_valid", 64'd1, 64'd0);
      end else begin
        e = expq[0];
        check("model_q", o_q, e.q);
        check("model_r", o_r, e.r);
        check("model_dbz", o_dbz, e.dbz);
        check("model_number", number, NUMBER_EXP);
        if (e.b != 0) begin
          check("q_times_b_plus_r", int'(o_q) * e.b + int'(o_r), e.a);
          check("r_below_b", (int'(o_r) < e.b), 1);
        end
      end
    end
  end

  task automatic run(input int a, input int b, input int hold,
                     output int q, output int r, output int dbz, output int lat);
    int n = 0;
    while (!o_in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_in_ready) check("in_ready_timeout", 64'd0, 64'd1);
    i_a = A_W'(a);
    i_b = B_W'(b);
    i_in_valid = 1'b1;
    i_out_ready = (hold == 0);
    @(posedge clk); #1;
    last_acc = cyc;
    i_in_valid = 1'b0;
    lat = 0;
    while (!o_out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!o_out_valid) check("out_valid_timeout", 64'd0, 64'd1);
    q = int'(o_q);
    r = int'(o_r);
    dbz = int'(o_dbz);
    for (int i = 0; i < hold; i++) begin
      // A stray request in the hold window must not be taken.
      if (i == 2) begin
        i_in_valid = 1'b1;
        i_a = 8'd9;
        i_b = 5'd2;
      end else begin
        i_in_valid = 1'b0;
      end
      @(posedge clk); #1;
      check("hold_valid", o_out_valid, 64'd1);
      check("hold_in_ready", o_in_ready, 64'd0);
      check("hold_q", o_q, q);
      check("hold_r", o_r, r);
    end
    i_in_valid = 1'b0;
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_handshake", o_in_ready, 64'd1);
    check("valid_drops_after_handshake", o_out_valid, 64'd0);
  endtask

  initial begin
    int q, r, dbz, lat, acc0, a;
    rst = 1'b1;
    i_in_valid = 1'b0;
    i_a = '0;
    i_b = '0;
    i_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", o_in_ready, 64'd1);
    check("rst_out_valid", o_out_valid, 64'd0);
    check("rst_q", o_q, 64'd0);
    check("rst_r", o_r, 64'd0);
    check("rst_dbz", o_dbz, 64'd0);
    check("rst_number", number, NUMBER_EXP);
    rst = 1'b0;

    run(200, 7, 0, q, r, dbz, lat);
    check("200_7_q", q, 28);
    check("200_7_r", r, 4);
    check("200_7_dbz", dbz, 0);
    check("200_7_latency", lat, 8);

    run(255, 31, 0, q, r, dbz, lat);
    acc0 = last_acc;
    check("255_31_q", q, 8);
    check("255_31_r", r, 7);
    run(0, 1, 0, q, r, dbz, lat);
    check("0_1_q", q, 0);
    check("0_1_r", r, 0);
    check("throughput_cycles", last_acc - acc0, 10);

    run(5, 0, 0, q, r, dbz, lat);
    check("5_0_q", q, 255);
    check("5_0_r", r, 5);
    check("5_0_dbz", dbz, 1);
    check("5_0_latency", lat, 1);

    run(100, 3, 6, q, r, dbz, lat);
    check("100_3_q", q, 33);
    check("100_3_r", r, 1);
    check("100_3_latency", lat, 8);

    // Abandon 77/9 partway through the iterations.
    i_a = 8'd77;
    i_b = 5'd9;
    i_in_valid = 1'b1;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("busy_in_ready", o_in_ready, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", o_in_ready, 64'd1);
    check("midrst_out_valid", o_out_valid, 64'd0);
    check("midrst_q", o_q, 64'd0);
    check("midrst_r", o_r, 64'd0);
    check("midrst_dbz", o_dbz, 64'd0);
    run(77, 9, 0, q, r, dbz, lat);
    check("77_9_q", q, 8);
    check("77_9_r", r, 5);

    for (int b = 0; b < 32; b++) begin
      for (int j = 0; j < 8; j++) begin
        if (j == 0) a = 0;
        else if (j == 1) a = 255;
        else a = int'($urandom_range(255));
        run(a, b, 0, q, r, dbz, lat);
        check("sweep_dbz", dbz, (b == 0) ? 1 : 0);
        check("sweep_latency", lat, (b == 0) ? 1 : 8);
      end
    end

    check("scoreboard_drained", expq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
